coin_acceptor: RTL
==================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive synchronized-high cycles that qualify a coin pulse (legal range 2..15).
REQ-002 Parameter CREDIT_MAX, default 250: maximum credit held, in sen.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port coin_10 / coin_20 / coin_50, input, 1 each: raw asynchronous coin-sensor levels for 10, 20 and 50 sen.
REQ-006 Port accept_en, input, 1: from the vm controller; high means coins may be credited.
REQ-007 Port credit_clr, input, 1: vm controller pulse meaning the vend has completed and credit is consumed.
REQ-008 Port refund_req, input, 1: refund button pulse, already synchronous.
REQ-009 Port credit, output, 8: accumulated credit in sen, registered.
REQ-010 Port credit_valid, output, 1: high when credit is nonzero, registered.
REQ-011 Port coin_accept / coin_reject, output, 1 each: one-cycle pulses driving the coin gate.
REQ-012 Port refund_valid, output, 1: one-cycle pulse; refund_amt is valid while it is high.
REQ-013 Port refund_amt, output, 8: amount to return; holds its last value otherwise.

Function
REQ-014 Each coin input SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 Each channel SHALL have a debounce counter: +1 per synchronized-high cycle, saturating at DEB_CYCLES; cleared on any synchronized-low cycle.
REQ-016 A channel SHALL raise exactly one coin event, on the cycle its counter first reaches DEB_CYCLES; a level held high for any longer SHALL NOT raise another event.
REQ-017 Latency: with a coin first sampled high at edge k and held high, credit and coin_accept SHALL update at edge k+2+DEB_CYCLES.
REQ-018 Simultaneous events on several channels SHALL be resolved with priority 50 > 20 > 10; only the winner may be credited; coin_reject SHALL pulse once for the losers.
REQ-019 A coin event SHALL be rejected (coin_reject pulse, credit unchanged) when accept_en is low or when credit + value > CREDIT_MAX.
REQ-020 An accepted coin SHALL add its value to credit and pulse coin_accept for one cycle; credit == CREDIT_MAX is legal.
REQ-021 FSM states: IDLE (credit = 0), CREDIT (credit > 0), REFUND (single cycle).
REQ-022 IDLE -> CREDIT on an accepted coin.
REQ-023 CREDIT -> IDLE on credit_clr, with credit set to 0 the next cycle.
REQ-024 CREDIT -> REFUND on refund_req: refund_amt = credit, refund_valid pulses for that cycle, credit = 0, then the FSM returns to IDLE.
REQ-025 refund_req in IDLE SHALL be ignored: no refund_valid pulse.
REQ-026 Simultaneous credit_clr and refund_req SHALL give credit_clr priority; no refund is issued.
REQ-027 A coin event in the same cycle as credit_clr or refund_req SHALL be applied after the clear: credit becomes the coin value, and any refund excludes that coin.
REQ-028 Coin events arriving while in REFUND SHALL be rejected.
REQ-029 All arithmetic SHALL be 9 bits wide internally; credit SHALL never wrap.

Reset
REQ-030 While rst_n is low: credit = 0, credit_valid = 0, coin_accept = 0, coin_reject = 0, refund_valid = 0, refund_amt = 0, synchronizers and counters cleared, FSM = IDLE.
REQ-031 Reset asserted mid-debounce or mid-refund SHALL abort with no event or pulse after release; a coin held high through release SHALL need a full new qualification.

Verification
REQ-032 coin_20 high 10 cycles, accept_en = 1 -> single coin_accept at edge k+6, credit = 20, credit_valid = 1.
REQ-033 coin_50 high for 2 cycles only -> no coin_accept, no coin_reject, credit unchanged.
REQ-034 credit = 230, then coin_50 -> coin_reject pulse, credit stays 230; then coin_20 -> credit = 250.
REQ-035 coin_10 and coin_50 qualify the same cycle -> credit += 50, one coin_accept and one coin_reject.
REQ-036 credit = 70, refund_req -> refund_valid for 1 cycle, refund_amt = 70, credit = 0; then refund_req again -> no refund_valid.
REQ-037 credit = 40, credit_clr and a coin_10 event in the same cycle -> credit = 10; rst_n pulsed low mid-debounce -> no event.

Source files
------------

// File: rtl/coin_acceptor.sv
// Three-channel coin acceptor: synchronizes and debounces the coin sensors, then
// credits coins into a small IDLE/CREDIT/REFUND state machine.
module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int CREDIT_MAX = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_10,
  input  logic       coin_20,
  input  logic       coin_50,
  input  logic       accept_en,
  input  logic       credit_clr,
  input  logic       refund_req,
  output logic [7:0] credit,
  output logic       credit_valid,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic       refund_valid,
  output logic [7:0] refund_amt
);

  localparam logic [3:0] DEB_LIM  = 4'(DEB_CYCLES);
  localparam logic [3:0] DEB_PRE  = 4'(DEB_CYCLES - 1);
  localparam logic [8:0] MAX9     = 9'(CREDIT_MAX);

  typedef enum logic [1:0] {IDLE, CREDIT, REFUND} state_t;

  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] evt;
  logic [3:0] cnt [3];

  state_t     state;
  state_t     state_next;
  logic [8:0] base;
  logic [8:0] sum;
  logic [8:0] coin_val;
  logic       has_loser;
  logic       accept_next;
  logic       reject_next;
  logic       refund_next;
  logic [7:0] refund_amt_next;

  // Channel index 0/1/2 = 10/20/50 sen.
  assign raw = {coin_50, coin_20, coin_10};

  // evt is registered off the transition DEB-1 -> DEB, so it fires once per high stretch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      evt   <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (!sync2[i])
          cnt[i] <= '0;
        else if (cnt[i] != DEB_LIM)
          cnt[i] <= cnt[i] + 4'd1;
        evt[i] <= sync2[i] && (cnt[i] == DEB_PRE);
      end
    end
  end

  always_comb begin
    state_next      = state;
    base            = {1'b0, credit};
    sum             = '0;
    coin_val        = '0;
    has_loser       = 1'b0;
    accept_next     = 1'b0;
    reject_next     = 1'b0;
    refund_next     = 1'b0;
    refund_amt_next = refund_amt;

    if (evt[2]) begin
      coin_val  = 9'd50;
      has_loser = evt[1] | evt[0];
    end else if (evt[1]) begin
      coin_val  = 9'd20;
      has_loser = evt[0];
    end else if (evt[0]) begin
      coin_val  = 9'd10;
    end

    // Clear/refund act first; a coin in the same cycle then lands on the cleared credit.
    case (state)
      CREDIT: begin
        if (credit_clr) begin
          base       = '0;
          state_next = IDLE;
        end else if (refund_req) begin
          refund_next     = 1'b1;
          refund_amt_next = credit;
          base            = '0;
          state_next      = REFUND;
        end
      end
      REFUND:  state_next = (credit != 8'd0) ? CREDIT : IDLE;
      default: ;
    endcase

    sum = base + coin_val;
    if (coin_val != 9'd0) begin
      if (state == REFUND || !accept_en || sum > MAX9) begin
        reject_next = 1'b1;
      end else begin
        accept_next = 1'b1;
        base        = sum;
        if (state_next == IDLE) state_next = CREDIT;
      end
      if (has_loser) reject_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      credit       <= '0;
      credit_valid <= 1'b0;
      coin_accept  <= 1'b0;
      coin_reject  <= 1'b0;
      refund_valid <= 1'b0;
      refund_amt   <= '0;
    end else begin
      state        <= state_next;
      credit       <= base[7:0];
      credit_valid <= (base != 9'd0);
      coin_accept  <= accept_next;
      coin_reject  <= reject_next;
      refund_valid <= refund_next;
      refund_amt   <= refund_amt_next;
    end
  end

endmodule
